// File: rtl/exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl_if
// Description : Bundle between the IR3 front end and the execute-stage
//               controller. It carries the IR3 handshake, the memory strobes,
//               the ALU selects and the retire/status outputs.
//   master : drives in_valid, instr, stall; receives everything else
//   slave  : the controller itself (exec_ctrl_seq)
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_ctrl_if #(
  parameter int ALUOP_W   = 3,
  parameter int ALU2SEL_W = 3,
  parameter int CNT_W     = 16
);
  logic                 in_valid;
  logic [3:0]           instr;
  logic                 stall;
  logic                 ir3_load;
  logic                 in_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mdr_load;
  logic [ALU2SEL_W-1:0] alu_2;
  logic [ALUOP_W-1:0]   alu_op;
  logic                 alu_out_write;
  logic                 flag_write;
  logic                 out_valid;
  logic                 stop;
  logic                 illegal;
  logic [CNT_W-1:0]     retired;

  modport master (
    output in_valid, instr, stall,
    input  ir3_load, in_ready, mem_read, mem_write, mdr_load, alu_2, alu_op,
           alu_out_write, flag_write, out_valid, stop, illegal, retired
  );

  modport slave (
    input  in_valid, instr, stall,
    output ir3_load, in_ready, mem_read, mem_write, mdr_load, alu_2, alu_op,
           alu_out_write, flag_write, out_valid, stop, illegal, retired
  );
endinterface
`default_nettype wire

// File: rtl/exec_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl_seq
// Description : Registered execute-stage controller. It accepts an opcode
//               from IR3 under a valid/ready handshake. One cycle later it
//               issues the ALU, flag and memory control for that opcode.
//               Loads and stores hold the memory strobes for MEM_WAIT
//               cycles. A stop opcode parks the stage in HALT until reset.
//               Illegal opcodes retire as a nop and set a sticky flag.
//               Retired instructions are counted.
// Ports       : clock - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - exec_ctrl_if.slave (handshake, strobes, status)
// Revision    : 1.0 - initial release
// ============================================================================
module exec_ctrl_seq #(
  parameter int ALUOP_W   = 3,
  parameter int ALU2SEL_W = 3,
  parameter int MEM_WAIT  = 1,
  parameter int CNT_W     = 16
) (
  input  wire logic   clock,
  input  wire logic   reset,
  exec_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_WAIT + 1);

  localparam logic [1:0] c_ST_RUN  = 2'd0;
  localparam logic [1:0] c_ST_MEM  = 2'd1;
  localparam logic [1:0] c_ST_HALT = 2'd2;

  localparam logic [2:0] c_CL_ALU   = 3'd0;
  localparam logic [2:0] c_CL_NOP   = 3'd1;
  localparam logic [2:0] c_CL_ILL   = 3'd2;
  localparam logic [2:0] c_CL_LOAD  = 3'd3;
  localparam logic [2:0] c_CL_STORE = 3'd4;
  localparam logic [2:0] c_CL_STOP  = 3'd5;

  localparam logic [ALU2SEL_W-1:0] c_SEL_R2   = ALU2SEL_W'(0);
  localparam logic [ALU2SEL_W-1:0] c_SEL_IMM5 = ALU2SEL_W'(3);
  localparam logic [ALU2SEL_W-1:0] c_SEL_IMM3 = ALU2SEL_W'(4);

  localparam logic [ALUOP_W-1:0] c_OP_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] c_OP_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] c_OP_OR    = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] c_OP_NAND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] c_OP_SHIFT = ALUOP_W'(4);

  logic [1:0]           r_state, w_state_nxt;
  logic [WAIT_W-1:0]    r_wait, w_wait_nxt;
  logic                 r_is_load, w_is_load_nxt;

  logic [2:0]           w_cls;
  logic [ALU2SEL_W-1:0] w_dec_alu2;
  logic [ALUOP_W-1:0]   w_dec_aluop;
  logic                 w_in_ready, w_accept;

  logic [ALU2SEL_W-1:0] r_alu_2, w_alu_2_nxt;
  logic [ALUOP_W-1:0]   r_alu_op, w_alu_op_nxt;
  logic                 r_mem_read, w_mem_read_nxt;
  logic                 r_mem_write, w_mem_write_nxt;
  logic                 r_mdr_load, w_mdr_load_nxt;
  logic                 r_alu_out_write, w_alu_out_write_nxt;
  logic                 r_flag_write, w_flag_write_nxt;
  logic                 r_out_valid, w_out_valid_nxt;
  logic                 r_stop, w_stop_nxt;
  logic                 r_illegal, w_illegal_nxt;
  logic [CNT_W-1:0]     r_retired;

  // Opcode decode. Shift and ori match on the low three bits only, so
  // opcodes 3/11 and 7/15 alias. Those checks take precedence over the
  // full 4-bit table.
  always_comb begin
    w_cls       = c_CL_ILL;
    w_dec_alu2  = c_SEL_R2;
    w_dec_aluop = c_OP_OR;
    if (bus.instr[2:0] == 3'd3) begin
      w_cls       = c_CL_ALU;
      w_dec_alu2  = c_SEL_IMM3;
      w_dec_aluop = c_OP_SHIFT;
    end else if (bus.instr[2:0] == 3'd7) begin
      w_cls       = c_CL_ALU;
      w_dec_alu2  = c_SEL_IMM5;
      w_dec_aluop = c_OP_OR;
    end else begin
      case (bus.instr)
        4'd4:    begin w_cls = c_CL_ALU; w_dec_aluop = c_OP_ADD;  end
        4'd6:    begin w_cls = c_CL_ALU; w_dec_aluop = c_OP_SUB;  end
        4'd8:    begin w_cls = c_CL_ALU; w_dec_aluop = c_OP_NAND; end
        4'd0:    w_cls = c_CL_LOAD;
        4'd2:    w_cls = c_CL_STORE;
        4'd10:   w_cls = c_CL_NOP;
        4'd1:    w_cls = c_CL_STOP;
        default: w_cls = c_CL_ILL;
      endcase
    end
  end

  // The reset term keeps ready low for the whole time reset is held.
  // During that time the state register already reads RUN.
  assign w_in_ready   = reset & (r_state == c_ST_RUN) & ~bus.stall;
  assign w_accept     = bus.in_valid & w_in_ready;
  assign bus.in_ready = w_in_ready;
  assign bus.ir3_load = w_accept;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= c_ST_RUN;
      r_wait    <= '0;
      r_is_load <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_is_load <= w_is_load_nxt;
    end
  end

  // Next-state logic. r_wait holds the number of MEM cycles still to go,
  // counting the current one.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait;
    w_is_load_nxt = r_is_load;
    case (r_state)
      c_ST_RUN: begin
        if (w_accept) begin
          if (w_cls == c_CL_LOAD || w_cls == c_CL_STORE) begin
            w_state_nxt   = c_ST_MEM;
            w_wait_nxt    = WAIT_W'(MEM_WAIT);
            w_is_load_nxt = (w_cls == c_CL_LOAD);
          end else if (w_cls == c_CL_STOP) begin
            w_state_nxt = c_ST_HALT;
          end
        end
      end
      c_ST_MEM: begin
        w_wait_nxt = r_wait - WAIT_W'(1);
        if (r_wait == WAIT_W'(1)) w_state_nxt = c_ST_RUN;
      end
      c_ST_HALT: w_state_nxt = c_ST_HALT;
      default:   w_state_nxt = c_ST_RUN;
    endcase
  end

  // Output logic. It computes the control word for the next cycle, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    w_alu_2_nxt         = c_SEL_R2;
    w_alu_op_nxt        = c_OP_OR;
    w_mem_read_nxt      = 1'b0;
    w_mem_write_nxt     = 1'b0;
    w_mdr_load_nxt      = 1'b0;
    w_alu_out_write_nxt = 1'b0;
    w_flag_write_nxt    = 1'b0;
    w_out_valid_nxt     = 1'b0;
    w_stop_nxt          = r_stop | (w_state_nxt == c_ST_HALT);
    w_illegal_nxt       = r_illegal | (w_accept && w_cls == c_CL_ILL);
    if (w_state_nxt == c_ST_MEM) begin
      w_mem_read_nxt  = w_is_load_nxt;
      w_mem_write_nxt = ~w_is_load_nxt;
      if (w_wait_nxt == WAIT_W'(1)) begin
        w_mdr_load_nxt  = w_is_load_nxt;
        w_out_valid_nxt = 1'b1;
      end
    end else if (r_state == c_ST_RUN && w_accept) begin
      case (w_cls)
        c_CL_ALU: begin
          w_alu_2_nxt         = w_dec_alu2;
          w_alu_op_nxt        = w_dec_aluop;
          w_alu_out_write_nxt = 1'b1;
          w_flag_write_nxt    = 1'b1;
          w_out_valid_nxt     = 1'b1;
        end
        c_CL_NOP, c_CL_ILL: w_out_valid_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alu_2         <= c_SEL_R2;
      r_alu_op        <= c_OP_OR;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mdr_load      <= 1'b0;
      r_alu_out_write <= 1'b0;
      r_flag_write    <= 1'b0;
      r_out_valid     <= 1'b0;
      r_stop          <= 1'b0;
      r_illegal       <= 1'b0;
      r_retired       <= '0;
    end else begin
      r_alu_2         <= w_alu_2_nxt;
      r_alu_op        <= w_alu_op_nxt;
      r_mem_read      <= w_mem_read_nxt;
      r_mem_write     <= w_mem_write_nxt;
      r_mdr_load      <= w_mdr_load_nxt;
      r_alu_out_write <= w_alu_out_write_nxt;
      r_flag_write    <= w_flag_write_nxt;
      r_out_valid     <= w_out_valid_nxt;
      r_stop          <= w_stop_nxt;
      r_illegal       <= w_illegal_nxt;
      if (r_out_valid) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.alu_2         = r_alu_2;
  assign bus.alu_op        = r_alu_op;
  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;
  assign bus.mdr_load      = r_mdr_load;
  assign bus.alu_out_write = r_alu_out_write;
  assign bus.flag_write    = r_flag_write;
  assign bus.out_valid     = r_out_valid;
  assign bus.stop          = r_stop;
  assign bus.illegal       = r_illegal;
  assign bus.retired       = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_ctrl_seq
// Description : Scoreboard bench for exec_ctrl_seq (MEM_WAIT=3, CNT_W=4).
//               The stimulus queues the control word it expects for each
//               accepted opcode. A negedge monitor pops one entry on every
//               out_valid cycle and compares it with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_ctrl_seq;

  localparam int c_MEM_WAIT = 3;
  localparam int c_CNT_W    = 4;

  typedef struct packed {
    logic [2:0] alu2;
    logic [2:0] aluop;
    logic       aw;
    logic       fw;
    logic       mdr;
    logic       mr;
    logic       mw;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   exp_ret;
  exp_t sbq[$];
  exp_t mon_e;
  exp_t mon_a;

  exec_ctrl_if #(.ALUOP_W(3), .ALU2SEL_W(3), .CNT_W(c_CNT_W)) bus ();

  exec_ctrl_seq #(
    .ALUOP_W(3), .ALU2SEL_W(3), .MEM_WAIT(c_MEM_WAIT), .CNT_W(c_CNT_W)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t rec(input int a2, input int op, input bit aw, input bit mdr,
                               input bit mr, input bit mw);
    exp_t e;
    e.alu2 = 3'(a2); e.aluop = 3'(op); e.aw = aw; e.fw = aw;
    e.mdr = mdr; e.mr = mr; e.mw = mw;
    return e;
  endfunction

  // Monitor: every retiring cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        mon_a = '{alu2: bus.alu_2, aluop: bus.alu_op, aw: bus.alu_out_write,
                  fw: bus.flag_write, mdr: bus.mdr_load, mr: bus.mem_read,
                  mw: bus.mem_write};
        check("ctrl_word", 32'(mon_a), 32'(mon_e));
        check("retired_at_retire", 32'(bus.retired), 32'(exp_ret));
        exp_ret = (exp_ret + 1) % (1 << c_CNT_W);
      end
    end
  end

  task automatic send(input logic [3:0] op, input bit expect_out, input exp_t e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.instr    = op;
    bus.stall    = 1'b0;
    #1;
    check($sformatf("ir3_load_op%0d", op), 32'(bus.ir3_load), 32'd1);
    if (expect_out) sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    #1;
  endtask

  task automatic do_reset_checks();
    check("rst_stop", 32'(bus.stop), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_retired", 32'(bus.retired), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_strobes", 32'({bus.out_valid, bus.mem_read, bus.mem_write, bus.mdr_load,
                              bus.alu_out_write, bus.flag_write}), 32'd0);
    check("rst_alu_sel", 32'({bus.alu_2, bus.alu_op}), 32'h02);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_ret = 0;
    bus.in_valid = 1'b0; bus.instr = 4'd0; bus.stall = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state, with a valid opcode offered while reset is held
    @(negedge clk);
    bus.in_valid = 1'b1; bus.instr = 4'd4;
    #1;
    check("rst_ir3_load", 32'(bus.ir3_load), 32'd0);
    do_reset_checks();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // add, sub, nand back-to-back, then a stalled offer (no accept)
    send(4'd4, 1, rec(0, 0, 1, 0, 0, 0));
    send(4'd6, 1, rec(0, 1, 1, 0, 0, 0));
    send(4'd8, 1, rec(0, 3, 1, 0, 0, 0));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.instr = 4'd6; bus.stall = 1'b1;
    #1;
    check("stall_ir3_load", 32'(bus.ir3_load), 32'd0);
    idle();
    check("retired_after_alu3", 32'(bus.retired), 32'd3);

    // Load, MEM_WAIT=3: three MEM cycles, then ready again
    send(4'd0, 1, rec(0, 2, 0, 1, 1, 0));
    for (int i = 1; i <= 4; i++) begin
      idle();
      check($sformatf("load_in_ready_c%0d", i), 32'(bus.in_ready), 32'(i == 4));
      check($sformatf("load_mem_read_c%0d", i), 32'(bus.mem_read), 32'(i < 4));
      check($sformatf("load_mdr_load_c%0d", i), 32'(bus.mdr_load), 32'(i == 3));
    end

    // shift (0xB), ori (0xF), illegal 13, then nop
    send(4'hB, 1, rec(4, 4, 1, 0, 0, 0));
    send(4'hF, 1, rec(3, 2, 1, 0, 0, 0));
    send(4'd13, 1, rec(0, 2, 0, 0, 0, 0));
    idle();
    check("illegal_set", 32'(bus.illegal), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("illegal_held", 32'(bus.illegal), 32'd1);
    send(4'd10, 1, rec(0, 2, 0, 0, 0, 0));

    // stop, then add held valid: no further accepts, count frozen at 8
    send(4'd1, 0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.instr = 4'd4;
      #1;
      check($sformatf("halt_ir3_load_%0d", i), 32'(bus.ir3_load), 32'd0);
      check($sformatf("halt_stop_%0d", i), 32'(bus.stop), 32'd1);
      check($sformatf("halt_retired_%0d", i), 32'(bus.retired), 32'd8);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    do_reset_checks();
    sbq.delete();
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Store aborted by reset in its first MEM cycle
    send(4'd2, 0, '0);
    idle();
    check("store_mem_write_on", 32'(bus.mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("store_mem_write_async_off", 32'(bus.mem_write), 32'd0);
    check("store_abort_retired", 32'(bus.retired), 32'd0);
    sbq.delete();
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // 17 nops from zero: the 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) send(4'd10, 1, rec(0, 2, 0, 0, 0, 0));
    idle();
    @(negedge clk);
    #1;
    check("retired_wrap", 32'(bus.retired), 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
